// File: rtl/vga_text_attr_ram.sv
// Text/attribute RAM: CPU read/write port, video scan-out read port, optional clear-screen fill engine.
// The fill engine is built only when VGA_TXTRAM_FILL_EN is defined; otherwise this is a plain dual-port RAM.
module vga_text_attr_ram #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 11,
  parameter logic [31:0] INIT_VAL = 32'h0000_0007
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic [AW-1:0] vaddr,
  output logic [DW-1:0] vdata,
  input  logic          fill_req,
  input  logic [DW-1:0] fill_val,
  output logic          fill_busy
);

  localparam int unsigned   DEPTH  = 2 ** AW;
  localparam logic [DW-1:0] INIT_W = INIT_VAL[DW-1:0];

  logic [DW-1:0] mem_r [DEPTH] = '{default: INIT_W};
  logic [DW-1:0] rdata_r;
  logic [DW-1:0] vdata_r;

  logic          busy_s;
  logic          fill_wr_s;
  logic [AW-1:0] fill_addr_s;
  logic [DW-1:0] fill_data_s;
  logic          cpu_wr_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_wa_s;
  logic [DW-1:0] mem_wd_s;

`ifdef VGA_TXTRAM_FILL_EN
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_t;

  fill_state_t   state_r, state_nxt_s;
  logic [AW-1:0] cnt_r, cnt_nxt_s;
  logic [DW-1:0] fval_r, fval_nxt_s;
  logic          busy_r, busy_nxt_s;

  // Fill engine next-state: counter runs 0..all-ones once, then returns to idle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    fval_nxt_s  = fval_r;
    busy_nxt_s  = busy_r;
    fill_wr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fill_req) begin
          state_nxt_s = ST_FILL;
          cnt_nxt_s   = {AW{1'b0}};
          fval_nxt_s  = fill_val;
          busy_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        fill_wr_s = 1'b1;
        if (cnt_r == {AW{1'b1}}) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r + AW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // Fill engine state register; reset also discards a request arriving with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {AW{1'b0}};
      fval_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      fval_r  <= fval_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign busy_s      = busy_r;
  assign fill_addr_s = cnt_r;
  assign fill_data_s = fval_r;
`else
  logic unused_fill_s;
  assign unused_fill_s = ^{fill_req, fill_val};
  assign busy_s        = 1'b0;
  assign fill_wr_s     = 1'b0;
  assign fill_addr_s   = {AW{1'b0}};
  assign fill_data_s   = {DW{1'b0}};
`endif

  assign cpu_wr_s = cs & we & ~busy_s;

  // Single write port: fill and CPU writes are mutually exclusive because busy blocks the CPU.
  always_comb begin
    mem_we_s = 1'b0;
    mem_wa_s = addr;
    mem_wd_s = wdata;
    if (fill_wr_s && !rst) begin
      mem_we_s = 1'b1;
      mem_wa_s = fill_addr_s;
      mem_wd_s = fill_data_s;
    end else if (cpu_wr_s) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Array write; reset never touches contents.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // Registered read ports: video is read-first against a same-cycle write, CPU is write-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DW{1'b0}};
      vdata_r <= {DW{1'b0}};
    end else begin
      vdata_r <= mem_r[vaddr];
      if (cs && !busy_s) begin
        if (we) begin
          rdata_r <= wdata;
        end else begin
          rdata_r <= mem_r[addr];
        end
      end
    end
  end

  assign rdata     = rdata_r;
  assign vdata     = vdata_r;
  assign fill_busy = busy_s;

endmodule

// File: tb/tb_vga_text_attr_ram.sv
// Directed self-checking bench for vga_text_attr_ram (default parameters).
// Fill-engine scenarios are exercised when VGA_TXTRAM_FILL_EN is defined, the compiled-out behaviour otherwise.
module tb_vga_text_attr_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [10:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [10:0] vaddr;
  logic [7:0]  vdata;
  logic        fill_req;
  logic [7:0]  fill_val;
  logic        fill_busy;

  int checks = 0;
  int errors = 0;

  vga_text_attr_ram dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vaddr(vaddr), .vdata(vdata), .fill_req(fill_req), .fill_val(fill_val), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = 11'd0; wdata = 8'd0;
    vaddr = 11'd0; fill_req = 1'b0; fill_val = 8'd0;
    step(); step();
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if (vdata !== 8'h00) begin errors++; $display("FAIL reset_vdata got %h exp 00", vdata); end
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", fill_busy); end
    rst = 1'b0;
  endtask

  task automatic test_powerup();
    logic [10:0] a [3] = '{11'd0, 11'd1, 11'd2047};
    for (int i = 0; i < 3; i++) begin
      cs = 1'b1; we = 1'b0; addr = a[i];
      step();
      checks++; if (rdata !== 8'h07) begin errors++; $display("FAIL powerup_cpu addr %0d got %h exp 07", a[i], rdata); end
    end
    cs = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      vaddr = 11'(i);
      step();
      checks++; if (vdata !== 8'h07) begin errors++; $display("FAIL powerup_video addr %0d got %h exp 07", i, vdata); end
    end
  endtask

  task automatic test_collision();
    cs = 1'b1; we = 1'b1; addr = 11'h123; wdata = 8'h1E; vaddr = 11'h123;
    step();
    cs = 1'b0; we = 1'b0;
    checks++; if (rdata !== 8'h1E) begin errors++; $display("FAIL collision_rdata got %h exp 1e", rdata); end
    checks++; if (vdata !== 8'h07) begin errors++; $display("FAIL collision_vdata_old got %h exp 07", vdata); end
    step();
    checks++; if (vdata !== 8'h1E) begin errors++; $display("FAIL collision_vdata_new got %h exp 1e", vdata); end
  endtask

  task automatic test_cpu_port();
    cs = 1'b0; addr = 11'd0;
    step();
    checks++; if (rdata !== 8'h1E) begin errors++; $display("FAIL cs_hold got %h exp 1e", rdata); end
    cs = 1'b1; we = 1'b1; addr = 11'd0; wdata = 8'hAA;
    step();
    checks++; if (rdata !== 8'hAA) begin errors++; $display("FAIL write_first_0 got %h exp aa", rdata); end
    addr = 11'd2047; wdata = 8'h55;
    step();
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL write_first_2047 got %h exp 55", rdata); end
    we = 1'b0; addr = 11'd0;
    step();
    checks++; if (rdata !== 8'hAA) begin errors++; $display("FAIL readback_0 got %h exp aa", rdata); end
    addr = 11'd2047;
    step();
    checks++; if (rdata !== 8'h55) begin errors++; $display("FAIL readback_2047 got %h exp 55", rdata); end
    addr = 11'd1;
    step();
    checks++; if (rdata !== 8'h07) begin errors++; $display("FAIL readback_1 got %h exp 07", rdata); end
    addr = 11'h123;
    step();
    checks++; if (rdata !== 8'h1E) begin errors++; $display("FAIL readback_123 got %h exp 1e", rdata); end
    cs = 1'b0;
  endtask

`ifdef VGA_TXTRAM_FILL_EN
  task automatic test_fill();
    int n;
    fill_req = 1'b1; fill_val = 8'h4F;
    step();
    fill_req = 1'b0; fill_val = 8'h00;
    checks++; if (fill_busy !== 1'b1) begin errors++; $display("FAIL fill_busy_start got %b exp 1", fill_busy); end
    n = 1;
    while (fill_busy === 1'b1 && n < 5000) begin
      cs = (n == 10 || n == 20); we = (n == 10); addr = 11'd5; wdata = 8'h00;
      step();
      if (fill_busy === 1'b1) n++;
    end
    cs = 1'b0; we = 1'b0;
    checks++; if (n != 2048) begin errors++; $display("FAIL fill_duration got %0d exp 2048", n); end
    checks++; if (rdata !== 8'h1E) begin errors++; $display("FAIL fill_rdata_hold got %h exp 1e", rdata); end
    cs = 1'b1; addr = 11'd5;
    step();
    cs = 1'b0;
    checks++; if (rdata !== 8'h4F) begin errors++; $display("FAIL fill_dropped_write got %h exp 4f", rdata); end
    for (int i = 0; i < 2048; i++) begin
      vaddr = 11'(i);
      step();
      checks++; if (vdata !== 8'h4F) begin errors++; $display("FAIL fill_content addr %0d got %h exp 4f", i, vdata); end
    end
  endtask

  task automatic test_req_while_busy();
    int n;
    fill_req = 1'b1; fill_val = 8'h4F;
    step();
    fill_req = 1'b0;
    n = 1;
    while (fill_busy === 1'b1 && n < 5000) begin
      fill_req = (n == 500); fill_val = (n == 500) ? 8'h11 : 8'h00;
      step();
      if (fill_busy === 1'b1) n++;
    end
    fill_req = 1'b0;
    checks++; if (n != 2048) begin errors++; $display("FAIL busy_req_duration got %0d exp 2048", n); end
    for (int i = 0; i < 2048; i++) begin
      vaddr = 11'(i);
      step();
      checks++; if (vdata !== 8'h4F) begin errors++; $display("FAIL busy_req_content addr %0d got %h exp 4f", i, vdata); end
    end
  endtask

  task automatic test_reset_mid_fill();
    fill_req = 1'b1; fill_val = 8'h20;
    step();
    fill_req = 1'b0;
    repeat (99) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL midfill_busy got %b exp 0", fill_busy); end
    step();
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL midfill_busy_stays got %b exp 0", fill_busy); end
    for (int i = 0; i < 99; i++) begin
      vaddr = 11'(i);
      step();
      checks++; if (vdata !== 8'h20) begin errors++; $display("FAIL midfill_new addr %0d got %h exp 20", i, vdata); end
    end
    vaddr = 11'd150;
    step();
    checks++; if (vdata !== 8'h4F) begin errors++; $display("FAIL midfill_old addr 150 got %h exp 4f", vdata); end
    cs = 1'b1; we = 1'b0; addr = 11'd150;
    step();
    cs = 1'b0;
    checks++; if (rdata !== 8'h4F) begin errors++; $display("FAIL midfill_cpu_read got %h exp 4f", rdata); end
  endtask

  task automatic test_req_with_rst();
    rst = 1'b1; fill_req = 1'b1; fill_val = 8'h33;
    step();
    rst = 1'b0; fill_req = 1'b0;
    step();
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL rst_req_busy got %b exp 0", fill_busy); end
    vaddr = 11'd0;
    step();
    checks++; if (vdata !== 8'h20) begin errors++; $display("FAIL rst_req_content got %h exp 20", vdata); end
  endtask
`else
  task automatic test_fill_disabled();
    fill_req = 1'b1; fill_val = 8'hFF;
    step();
    fill_req = 1'b0;
    checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL nofill_busy got %b exp 0", fill_busy); end
    cs = 1'b1; we = 1'b1; addr = 11'd10; wdata = 8'h3C;
    step();
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL nofill_write got %h exp 3c", rdata); end
    we = 1'b0; addr = 11'd11;
    step();
    checks++; if (rdata !== 8'h07) begin errors++; $display("FAIL nofill_unchanged got %h exp 07", rdata); end
    addr = 11'd10;
    step();
    checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL nofill_readback got %h exp 3c", rdata); end
    cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vaddr = (i == 0) ? 11'd0 : (i == 1) ? 11'h123 : (i == 2) ? 11'd2047 : 11'd500;
      step();
      checks++;
      if (vdata !== ((i == 0) ? 8'hAA : (i == 1) ? 8'h1E : (i == 2) ? 8'h55 : 8'h07)) begin
        errors++; $display("FAIL nofill_content idx %0d got %h", i, vdata);
      end
      checks++; if (fill_busy !== 1'b0) begin errors++; $display("FAIL nofill_busy_stays got %b exp 0", fill_busy); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_collision();
    test_cpu_port();
`ifdef VGA_TXTRAM_FILL_EN
    test_fill();
    test_req_while_busy();
    test_reset_mid_fill();
    test_req_with_rst();
`else
    test_fill_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
